// File: rtl/riscv_scoreboard_hazard_unit.sv
// Countdown scoreboard for variable-latency producers plus N-way EX forwarding selects.
// Optional perf counters are enabled with `define RISCV_HAZARD_PERF_EN.
module riscv_scoreboard_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned MAX_LAT    = 8,
    parameter int unsigned LAT_W      = $clog2(MAX_LAT + 1),
    parameter int unsigned SEL_W      = $clog2(NUM_FWD + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_rs1,
    input  logic [REG_ADDR_W-1:0]         id_rs2,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_reg_write,
    input  logic [LAT_W-1:0]              id_lat,
    input  logic                          flush,
    input  logic [REG_ADDR_W-1:0]         ex_rs1,
    input  logic [REG_ADDR_W-1:0]         ex_rs2,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_we,
    output logic                          stall,
    output logic [SEL_W-1:0]              forward_rs1,
    output logic [SEL_W-1:0]              forward_rs2,
    output logic [2**REG_ADDR_W-1:0]      sb_busy
`ifdef RISCV_HAZARD_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cycles,
    output logic [31:0]                   perf_raw_events
`endif
);

    localparam int unsigned NREG = 2**REG_ADDR_W;

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [LAT_W-1:0] lat_e;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             issue;

    always_comb begin
        if (id_lat == '0) begin
            lat_e = LAT_W'(1);
        end else if (id_lat > LAT_W'(MAX_LAT)) begin
            lat_e = LAT_W'(MAX_LAT);
        end else begin
            lat_e = id_lat;
        end
    end

    // A count of 1 means the result is forwardable next cycle, so only >1 stalls.
    assign raw1  = id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] > LAT_W'(1));
    assign raw2  = id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] > LAT_W'(1));
    assign waw   = id_reg_write && (id_rd != '0) && (cnt_q[id_rd] > lat_e);
    assign stall = id_valid && !flush && (raw1 || raw2 || waw);
    assign issue = id_valid && !flush && !stall;

    always_comb begin
        cnt_d[0]  = '0;
        busy_d    = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (issue && id_reg_write && (id_rd == REG_ADDR_W'(r))) begin
                cnt_d[r] = lat_e;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end else begin
                cnt_d[r] = '0;
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign sb_busy = busy_q;

    // Walk oldest to youngest so the youngest matching stage overwrites the select.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        logic [SEL_W-1:0] sel;
        sel = '0;
        if (rs != '0) begin
            for (int unsigned k = NUM_FWD; k >= 1; k--) begin
                if (fwd_we[k-1] && (fwd_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
                    sel = SEL_W'(k);
                end
            end
        end
        return sel;
    endfunction

    assign forward_rs1 = fwd_sel(ex_rs1);
    assign forward_rs2 = fwd_sel(ex_rs2);

`ifdef RISCV_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_raw_q;
    logic        stall_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_raw_q   <= '0;
            stall_prev_q <= 1'b0;
        end else begin
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (stall && !stall_prev_q && (raw1 || raw2)) begin
                perf_raw_q <= perf_raw_q + 32'd1;
            end
            stall_prev_q <= stall;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_raw_events   = perf_raw_q;
`endif

endmodule

// File: tb/tb_riscv_scoreboard_hazard_unit.sv
// Directed and randomized checks of the hazard unit against an integer-array scoreboard model.
module tb_riscv_scoreboard_hazard_unit;

    localparam int RW  = 5;
    localparam int NF  = 2;
    localparam int ML  = 8;
    localparam int LW  = $clog2(ML + 1);
    localparam int SW  = $clog2(NF + 1);
    localparam int NR  = 2**RW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid = 1'b0;
    logic [RW-1:0]     id_rs1 = '0;
    logic [RW-1:0]     id_rs2 = '0;
    logic              id_rs1_used = 1'b0;
    logic              id_rs2_used = 1'b0;
    logic [RW-1:0]     id_rd = '0;
    logic              id_reg_write = 1'b0;
    logic [LW-1:0]     id_lat = '0;
    logic              flush = 1'b0;
    logic [RW-1:0]     ex_rs1 = '0;
    logic [RW-1:0]     ex_rs2 = '0;
    logic [NF*RW-1:0]  fwd_rd = '0;
    logic [NF-1:0]     fwd_we = '0;
    logic              stall;
    logic [SW-1:0]     forward_rs1;
    logic [SW-1:0]     forward_rs2;
    logic [NR-1:0]     sb_busy;

    riscv_scoreboard_hazard_unit #(
        .REG_ADDR_W(RW),
        .NUM_FWD   (NF),
        .MAX_LAT   (ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_lat      (id_lat),
        .flush       (flush),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .fwd_rd      (fwd_rd),
        .fwd_we      (fwd_we),
        .stall       (stall),
        .forward_rs1 (forward_rs1),
        .forward_rs2 (forward_rs2),
        .sb_busy     (sb_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int m_cnt [NR];
    int m_late;
    bit m_stall;
    bit m_issue;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input int rs);
        int s;
        if (rs == 0) return 0;
        for (int k = 1; k <= NF; k++) begin
            s = int'(fwd_rd[(k-1)*RW +: RW]);
            if (fwd_we[k-1] && s != 0 && s == rs) return k;
        end
        return 0;
    endfunction

    // Settle the current inputs, predict from the model and compare.
    task automatic eval_chk();
        bit raw_a, raw_b, waw;
        logic [NR-1:0] busy;
        #2;
        m_late = (int'(id_lat) == 0) ? 1 : ((int'(id_lat) > ML) ? ML : int'(id_lat));
        raw_a  = id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] > 1;
        raw_b  = id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] > 1;
        waw    = id_reg_write && id_rd != 0 && m_cnt[id_rd] > m_late;
        m_stall = id_valid && !flush && (raw_a || raw_b || waw);
        m_issue = id_valid && !flush && !m_stall;
        busy = '0;
        for (int r = 1; r < NR; r++) busy[r] = (m_cnt[r] != 0);
        chk("stall", 64'(stall), 64'(m_stall));
        chk("fwd1", 64'(forward_rs1), 64'(ref_fwd(int'(ex_rs1))));
        chk("fwd2", 64'(forward_rs2), 64'(ref_fwd(int'(ex_rs2))));
        chk("busy", 64'(sb_busy), 64'(busy));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        end else begin
            for (int r = 1; r < NR; r++) begin
                if (m_issue && id_reg_write && int'(id_rd) == r) m_cnt[r] = m_late;
                else if (m_cnt[r] > 0) m_cnt[r]--;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr, input int lat);
        id_valid = v;  id_rs1 = RW'(rs1); id_rs1_used = u1;
        id_rs2 = RW'(rs2); id_rs2_used = u2;
        id_rd = RW'(rd); id_reg_write = wr; id_lat = LW'(lat);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_one(input int rd, input int lat);
        drive(1, 0, 0, 0, 0, rd, 1, lat);
        eval_chk();
        tick();
    endtask

    // Hold the current ID instruction until it issues; return cycles spent stalled.
    task automatic hold_until_issue(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            eval_chk();
            if (stall !== 1'b1) begin
                tick();
                return;
            end
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_stall = 0;
        m_issue = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // After reset: a reader of x3 with nothing in flight
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        eval_chk();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_busy", 64'(sb_busy), 64'd0);
        tick();

        // ALU lat 1 followed by dependent: no bubble
        issue_one(5, 1);
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        eval_chk();
        chk("alu_nostall", 64'(stall), 64'd0);
        tick();
        idle();
        eval_chk();
        chk("alu_retired", 64'(sb_busy[5]), 64'd0);
        tick();

        // Load lat 2: exactly one bubble
        issue_one(7, 2);
        drive(1, 0, 0, 7, 1, 0, 0, 0);
        eval_chk();
        chk("load_bubble", 64'(stall), 64'd1);
        tick();
        eval_chk();
        chk("load_go", 64'(stall), 64'd0);
        tick();

        // DIV lat 6: RAW consumer stalls 5 cycles
        issue_one(9, 6);
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        hold_until_issue(n);
        chk("div_raw_cycles", 64'(n), 64'd5);

        // DIV then WAW writer of x9 with lat 1
        issue_one(9, 6);
        drive(1, 0, 0, 0, 0, 9, 1, 1);
        hold_until_issue(n);
        chk("div_waw_cycles", 64'(n), 64'd5);
        idle();
        eval_chk();
        tick();

        // Latency saturates at MAX_LAT; zero latency behaves as 1
        issue_one(10, 15);
        drive(1, 0, 0, 10, 1, 0, 0, 0);
        hold_until_issue(n);
        chk("sat_cycles", 64'(n), 64'(ML - 1));
        issue_one(11, 0);
        drive(1, 11, 1, 0, 0, 0, 0, 0);
        eval_chk();
        chk("lat0_nostall", 64'(stall), 64'd0);
        tick();

        // Forwarding priority
        idle();
        fwd_we = 2'b11; fwd_rd = {5'd4, 5'd4}; ex_rs1 = 5'd4; ex_rs2 = 5'd0;
        eval_chk();
        chk("fwd_young", 64'(forward_rs1), 64'd1);
        chk("fwd_zero", 64'(forward_rs2), 64'd0);
        tick();
        fwd_we = 2'b10;
        eval_chk();
        chk("fwd_old", 64'(forward_rs1), 64'd2);
        tick();
        fwd_we = '0; ex_rs1 = '0;

        // Asynchronous reset mid-countdown
        issue_one(9, 6);
        idle();
        eval_chk();
        tick();
        eval_chk();
        chk("cnt9_busy", 64'(sb_busy[9]), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", 64'(sb_busy), 64'd0);
        chk("async_stall", 64'(stall), 64'd0);
        tick();
        rst = 1'b0;
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        eval_chk();
        chk("post_rst_stall", 64'(stall), 64'd0);
        tick();

        // Flush of a hazarding instruction records nothing
        issue_one(9, 6);
        drive(1, 9, 1, 0, 0, 12, 1, 3);
        flush = 1'b1;
        eval_chk();
        chk("flush_stall", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        eval_chk();
        chk("flush_norec", 64'(sb_busy[12]), 64'd0);
        tick();

        // Randomized traffic on a small register window to force collisions
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), 1'($urandom),
                  $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
                  1'($urandom), $urandom_range(0, 15));
            flush  = ($urandom_range(0, 9) == 0);
            ex_rs1 = RW'($urandom_range(0, 7));
            ex_rs2 = RW'($urandom_range(0, 7));
            fwd_rd = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
            fwd_we = NF'($urandom);
            eval_chk();
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
